pill_counter: RTL
=================

// Module: pill_counter
// PURPOSE
//   Counts pills dropped into the current bottle from the drop-sensor pulse train. Presents the
//   running count as two BCD digits (nowL/nowH) and rolls over to a fresh bottle once the count
//   reaches capacity (maxL/maxH). Sits directly upstream of the filled-bottle counter, which
//   counts one bottle for every cycle in which nowH:nowL equals maxH:maxL while working.
// PARAMETERS
//   SYNC_STAGES  2   flip-flop stages synchronising the asynchronous pill input (>=2)
//   SWAP_CYCLES  8   cycles spent in bottle changeover after a full bottle (>=1)
//   DEB_CYCLES   4   cycles pill_sync must be stable before it is accepted (DEBOUNCE_EN only)
// PORTS
//   CLK          in   1  system clock, rising edge
//   RST_n        in   1  asynchronous active-low reset
//   EN_work      in   1  global work enable
//   EN_set       in   1  setting-mode enable
//   set          in   1  clear request (effective with EN_work & EN_set)
//   isWork       in   1  bottling line running
//   pill         in   1  drop-sensor pulse, asynchronous, active high
//   maxL         in   4  capacity, BCD units digit
//   maxH         in   4  capacity, BCD tens digit
//   nowL         out  4  pills in current bottle, BCD units digit
//   nowH         out  4  pills in current bottle, BCD tens digit
//   bottle_full  out  1  one-cycle pulse, coincident with nowH:nowL == maxH:maxL
//   swap_busy    out  1  high during bottle changeover; pills are ignored
// BEHAVIOUR
//   Reset (RST_n=0, async): nowL=nowH=0, bottle_full=0, swap_busy=0, state=IDLE, sync/debounce regs=0.
//   clr = EN_work & EN_set & set; run = EN_work & isWork & ~EN_set & ~set (evaluated every cycle).
//   Capacity: each max digit >9 is treated as 9. cap = 10*maxH' + maxL'. cap==0 -> stay in IDLE.
//   Pill event: a rising edge of the synchronised (and, if enabled, debounced) pill signal.
//     At most one event per cycle. Latency pin->event = SYNC_STAGES+1 cycles (no debounce).
//   FSM states IDLE, FILL, FULL, SWAP:
//     IDLE: outputs 0. run & cap!=0 -> FILL.
//     FILL: on run & event: BCD increment (L==9 -> L=0, H+1). If the new value == cap -> FULL.
//           ~run: hold the count, drop events (edge detector keeps tracking, so an event seen
//           while stalled is never replayed later).
//     FULL: exactly one cycle. now==cap and bottle_full=1; the downstream bottle counter sees
//           exactly one matching cycle per bottle. Always -> SWAP on the next cycle.
//     SWAP: nowL=nowH=0, swap_busy=1, events dropped. Timer counts SWAP_CYCLES cycles while
//           run is high and holds while run is low. Expiry -> FILL.
//   clr in any state (highest priority below reset) -> IDLE, count=0, timer=0, bottle_full=0.
//   A capacity change during FILL takes effect immediately. If count >= new cap, the next event
//     is compared with == only, so the count runs on to 99 and then wraps to 00 with no
//     full pulse. Operators must clear (set) after changing capacity.
//   Count 99 with cap 99: the event yields 99 -> FULL. The count never exceeds 99.
//   Outputs are registered and glitch-free. bottle_full is never high outside FULL.
// CONFIGURATION
//   DEBOUNCE_EN defined: a change on pill_sync is accepted only after DEB_CYCLES consecutive
//     identical samples. Adds DEB_CYCLES to the latency. Pulses shorter than DEB_CYCLES are ignored.
//   DEBOUNCE_EN undefined: no filter. Every synchronised rising edge is an event.
//     DEB_CYCLES is unused.
// STRUCTURE
//   Shared package pill_pkg: state enum {IDLE,FILL,FULL,SWAP}, BCD digit typedef (4-bit),
//     BCD_MAX=4'd9, and the bcd_clamp/bcd_inc functions, which are reused by the bottle counter.
//   One sub-module, pill_edge_detect: synchroniser, optional debouncer and rising-edge pulse.
//   Top level: FSM, BCD counter, swap timer.
// TESTING
//   cap=03, run, 3 pills spaced 10 cycles -> now 01,02,03; bottle_full 1 cycle at 03; 00 next cycle.
//   cap=12, 12 pills -> now passes 09->10 with correct BCD carry; full at 12; swap_busy 8 cycles.
//   Pill during SWAP, or with isWork=0 in FILL -> count unchanged; no late increment after resume.
//   Set clear at count 05 (EN_work=EN_set=set=1) -> next cycle now=00, IDLE; RST_n low mid-SWAP
//     -> immediate zero outputs.
//   maxL=4'hC, maxH=0 -> cap treated as 09; cap=00 -> stays IDLE and pills are ignored.
//   DEBOUNCE_EN: 2-cycle pill glitch -> no count; 10-cycle pulse -> one count.

Source files
------------

// File: rtl/pill_pkg.sv
// Shared types and BCD helpers for the pill counter and the downstream bottle counter.

package pill_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StFull,
    StSwap
  } state_e;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic bcd_t bcd_clamp(bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // Two-digit BCD increment on {tens, units}; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(logic [7:0] v);
    bcd_t l;
    bcd_t h;
    l = v[3:0];
    h = v[7:4];
    if (l >= BCD_MAX) begin
      l = 4'd0;
      h = (h >= BCD_MAX) ? 4'd0 : h + 4'd1;
    end else begin
      l = l + 4'd1;
    end
    return {h, l};
  endfunction

endpackage

// File: rtl/pill_edge_detect.sv
// Synchroniser, optional debouncer and rising-edge pulse for the drop sensor.
// Define DEBOUNCE_EN to insert the DEB_CYCLES stability filter after the synchroniser.

module pill_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pill,
  output logic pill_event
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pill_sync;
  logic                   level;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pill};
    end
  end

  assign pill_sync = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt_q;
  logic          stable_q;

  // A new level is taken only after DEB_CYCLES consecutive samples disagree with the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      stable_q  <= 1'b0;
    end else if (pill_sync == stable_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_cnt_q <= '0;
      stable_q  <= pill_sync;
    end else begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  assign level = stable_q;
`else
  logic unused_deb_cycles;
  assign unused_deb_cycles = ^DEB_CYCLES;
  assign level = pill_sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign pill_event = level & ~prev_q;

endmodule

// File: rtl/pill_counter.sv
// Per-bottle pill counter: BCD count, full pulse and timed bottle changeover.
// Build option DEBOUNCE_EN enables the pill input debouncer in pill_edge_detect.

module pill_counter
  import pill_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SWAP_CYCLES = 8,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       EN_work,
  input  logic       EN_set,
  input  logic       set,
  input  logic       isWork,
  input  logic       pill,
  input  logic [3:0] maxL,
  input  logic [3:0] maxH,
  output logic [3:0] nowL,
  output logic [3:0] nowH,
  output logic       bottle_full,
  output logic       swap_busy
);

  localparam int unsigned TW = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SWAP_CYCLES - 1);

  logic          clr;
  logic          run;
  logic          pill_event;
  logic [7:0]    cap;
  logic          cap_zero;
  logic [7:0]    cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0] timer_q, timer_d;
  logic          full_q, full_d;
  logic          busy_q, busy_d;
  state_e        state_q, state_d;

  pill_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_edge (
    .clk        (CLK),
    .rst_n      (RST_n),
    .pill       (pill),
    .pill_event (pill_event)
  );

  assign clr      = EN_work & EN_set & set;
  assign run      = EN_work & isWork & ~EN_set & ~set;
  assign cap      = {bcd_clamp(maxH), bcd_clamp(maxL)};
  assign cap_zero = (cap == 8'h00);
  assign cnt_inc  = bcd_inc(cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    full_d  = 1'b0;
    busy_d  = 1'b0;
    if (clr) begin
      state_d = StIdle;
      cnt_d   = 8'h00;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = 8'h00;
          if (run && !cap_zero) state_d = StFill;
        end
        StFill: begin
          // Equality only: a count already past a lowered cap runs on and wraps silently.
          if (run && pill_event) begin
            cnt_d = cnt_inc;
            if (cnt_inc == cap && !cap_zero) begin
              state_d = StFull;
              full_d  = 1'b1;
            end
          end
        end
        StFull: begin
          state_d = StSwap;
          cnt_d   = 8'h00;
          timer_d = '0;
          busy_d  = 1'b1;
        end
        StSwap: begin
          busy_d = 1'b1;
          if (run) begin
            if (timer_q == TIMER_LAST) begin
              state_d = StFill;
              timer_d = '0;
              busy_d  = 1'b0;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'h00;
      timer_q <= '0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
    end
  end

  assign nowL        = cnt_q[3:0];
  assign nowH        = cnt_q[7:4];
  assign bottle_full = full_q;
  assign swap_busy   = busy_q;

endmodule
